// File: rtl/dual_commit_unit_if.sv
// Handshake bundle between issue stage, Branch/Memory pipes and the dual commit unit.
// slave modport is the commit unit; master modport is whatever drives it (issue/pipes/bench).
// All signals are plain wires; no storage lives here.
interface dual_commit_unit_if #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int REG_ADDR = 5
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                          flush;
  logic                          issue_valid;
  logic                          issue_ready;
  logic                          issue_br_valid;
  logic                          issue_mem_valid;
  logic [1:0]                    issue_priority;
  logic                          br_res_valid;
  logic                          br_res_ready;
  logic                          br_res_we;
  logic [REG_ADDR-1:0]           br_res_rd;
  logic [WIDTH-1:0]              br_res_data;
  logic                          mem_res_valid;
  logic                          mem_res_ready;
  logic                          mem_res_we;
  logic [REG_ADDR-1:0]           mem_res_rd;
  logic [WIDTH-1:0]              mem_res_data;
  logic [1:0]                    rf_we;
  logic [1:0][REG_ADDR-1:0]      rf_waddr;
  logic [1:0][WIDTH-1:0]         rf_wdata;
  logic [1:0]                    retire_count;
  logic [OCC_W-1:0]              occupancy;
  logic [31:0]                   retired_total;

  modport slave (
    input  flush, issue_valid, issue_br_valid, issue_mem_valid, issue_priority,
    input  br_res_valid, br_res_we, br_res_rd, br_res_data,
    input  mem_res_valid, mem_res_we, mem_res_rd, mem_res_data,
    output issue_ready, br_res_ready, mem_res_ready,
    output rf_we, rf_waddr, rf_wdata, retire_count, occupancy, retired_total
  );

  modport master (
    output flush, issue_valid, issue_br_valid, issue_mem_valid, issue_priority,
    output br_res_valid, br_res_we, br_res_rd, br_res_data,
    output mem_res_valid, mem_res_we, mem_res_rd, mem_res_data,
    input  issue_ready, br_res_ready, mem_res_ready,
    input  rf_we, rf_waddr, rf_wdata, retire_count, occupancy, retired_total
  );
endinterface

// File: rtl/dual_commit_unit.sv
// In-order dual-slot commit: buffers Branch/Memory results per issue pair, retires whole pairs, younger wins on WAW.
// Latency: result captured at edge N retires on rf_* after edge N+1; one pair per cycle; optional COMMIT_PERF_CNT_EN counter.
// Backpressure: issue_ready drops when DEPTH pairs are buffered or during flush; res_ready only when an entry awaits that pipe.
module dual_commit_unit #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int REG_ADDR = 5
) (
  input logic               clk,
  input logic               rst_n,
  dual_commit_unit_if.slave cu
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0]    exp_br_q, exp_mem_q, br_old_q, br_fill_q, mem_fill_q, br_we_q, mem_we_q;
  logic [REG_ADDR-1:0] br_rd_q  [DEPTH];
  logic [REG_ADDR-1:0] mem_rd_q [DEPTH];
  logic [WIDTH-1:0]    br_dat_q [DEPTH];
  logic [WIDTH-1:0]    mem_dat_q[DEPTH];

  logic [1:0]               rf_we_q, rf_we_d;
  logic [1:0][REG_ADDR-1:0] rf_waddr_q;
  logic [1:0][WIDTH-1:0]    rf_wdata_q;
  logic [1:0]               cnt_q;

  logic             br_hit, mem_hit, head_done, push, pop, br_acc, mem_acc;
  logic [PTR_W-1:0] br_sel, mem_sel, scan_idx;
  logic             o_real, o_we, y_real, y_we, o_wr, y_wr;
  logic [REG_ADDR-1:0] o_rd, y_rd;
  logic [WIDTH-1:0]    o_dat, y_dat;

  assign cu.issue_ready   = (occ_q < OCC_W'(DEPTH)) && !cu.flush;
  assign cu.br_res_ready  = br_hit && !cu.flush;
  assign cu.mem_res_ready = mem_hit && !cu.flush;
  assign br_acc  = cu.br_res_valid && cu.br_res_ready;
  assign mem_acc = cu.mem_res_valid && cu.mem_res_ready;
  // Empty descriptors are handshaken but occupy no slot.
  assign push = cu.issue_valid && cu.issue_ready && (cu.issue_br_valid || cu.issue_mem_valid);
  assign head_done = (occ_q != '0) && (!exp_br_q[head_q] || br_fill_q[head_q])
                                   && (!exp_mem_q[head_q] || mem_fill_q[head_q]);
  assign pop = head_done && !cu.flush;

  // Find the oldest buffered entry still waiting for each pipe (pipes return in order).
  always_comb begin
    br_hit   = 1'b0;
    mem_hit  = 1'b0;
    br_sel   = head_q;
    mem_sel  = head_q;
    scan_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (OCC_W'(k) < occ_q) begin
        if (!br_hit && exp_br_q[scan_idx] && !br_fill_q[scan_idx]) begin
          br_hit = 1'b1;
          br_sel = scan_idx;
        end
        if (!mem_hit && exp_mem_q[scan_idx] && !mem_fill_q[scan_idx]) begin
          mem_hit = 1'b1;
          mem_sel = scan_idx;
        end
      end
    end
  end

  // Order the head pair's slots by age and apply rd!=0 and younger-wins WAW masking.
  always_comb begin
    o_real = exp_br_q[head_q];  o_we = br_we_q[head_q];  o_rd = br_rd_q[head_q];  o_dat = br_dat_q[head_q];
    y_real = exp_mem_q[head_q]; y_we = mem_we_q[head_q]; y_rd = mem_rd_q[head_q]; y_dat = mem_dat_q[head_q];
    if (!br_old_q[head_q]) begin
      o_real = exp_mem_q[head_q]; o_we = mem_we_q[head_q]; o_rd = mem_rd_q[head_q]; o_dat = mem_dat_q[head_q];
      y_real = exp_br_q[head_q];  y_we = br_we_q[head_q];  y_rd = br_rd_q[head_q];  y_dat = br_dat_q[head_q];
    end
    o_wr = o_real && o_we && (o_rd != '0);
    y_wr = y_real && y_we && (y_rd != '0);
    rf_we_d = {y_wr, o_wr && !(y_wr && (o_rd == y_rd))};
  end

  // Pointer and occupancy next state: flush empties, otherwise +push -pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (cu.flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage: descriptor written at tail, results written into the selected waiting entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_br_q <= '0; exp_mem_q <= '0; br_old_q <= '0;
      br_fill_q <= '0; mem_fill_q <= '0; br_we_q <= '0; mem_we_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        br_rd_q[i]  <= '0; mem_rd_q[i]  <= '0;
        br_dat_q[i] <= '0; mem_dat_q[i] <= '0;
      end
    end else if (cu.flush) begin
      exp_br_q <= '0; exp_mem_q <= '0; br_fill_q <= '0; mem_fill_q <= '0;
    end else begin
      if (push) begin
        exp_br_q[tail_q]   <= cu.issue_br_valid;
        exp_mem_q[tail_q]  <= cu.issue_mem_valid;
        br_old_q[tail_q]   <= (cu.issue_priority != 2'b01);
        br_fill_q[tail_q]  <= 1'b0;
        mem_fill_q[tail_q] <= 1'b0;
      end
      if (br_acc) begin
        br_fill_q[br_sel] <= 1'b1;
        br_we_q[br_sel]   <= cu.br_res_we;
        br_rd_q[br_sel]   <= cu.br_res_rd;
        br_dat_q[br_sel]  <= cu.br_res_data;
      end
      if (mem_acc) begin
        mem_fill_q[mem_sel] <= 1'b1;
        mem_we_q[mem_sel]   <= cu.mem_res_we;
        mem_rd_q[mem_sel]   <= cu.mem_res_rd;
        mem_dat_q[mem_sel]  <= cu.mem_res_data;
      end
    end
  end

  // Retire port registers: enables/count are single-cycle pulses, address/data hold between retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else if (pop) begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= {y_rd, o_rd};
      rf_wdata_q <= {y_dat, o_dat};
      cnt_q      <= {1'b0, o_real} + {1'b0, y_real};
    end else begin
      rf_we_q <= '0;
      cnt_q   <= '0;
    end
  end

  assign cu.rf_we        = rf_we_q;
  assign cu.rf_waddr     = rf_waddr_q;
  assign cu.rf_wdata     = rf_wdata_q;
  assign cu.retire_count = cnt_q;
  assign cu.occupancy    = occ_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] total_q;
  // Running count of retired instructions; survives flush, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_q + {30'd0, cnt_q};
  end
  assign cu.retired_total = total_q;
`else
  assign cu.retired_total = '0;
`endif
endmodule

// File: tb/tb_dual_commit_unit.sv
// Bench for dual_commit_unit: directed cycle table, perf-counter sequence, randomized run against a queue model.
// Inputs driven on the falling edge; outputs sampled on the falling edge after the active edge.
// Model keeps buffered pairs in a queue and retires by the pair rules directly.
module tb_dual_commit_unit;
  localparam int W = 32, D = 4, RA = 5;
`ifdef COMMIT_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_commit_unit_if #(.WIDTH(W), .DEPTH(D), .REG_ADDR(RA)) cu ();
  dual_commit_unit #(.WIDTH(W), .DEPTH(D), .REG_ADDR(RA)) dut (.clk(clk), .rst_n(rst_n), .cu(cu));

  typedef struct packed {
    logic iv, bv, mv; logic [1:0] pri; logic fl;
    logic brv, bwe; logic [4:0] brd; logic [31:0] bd;
    logic mrv, mwe; logic [4:0] mrd; logic [31:0] md;
  } in_t;
  typedef struct packed {
    logic ir, brr, mrr; logic [2:0] occ; logic [1:0] we; logic [1:0] cnt; logic [1:0] chk;
    logic [4:0] wa0; logic [31:0] wd0; logic [4:0] wa1; logic [31:0] wd1;
  } ex_t;
  typedef struct packed { in_t i; ex_t e; } vec_t;
  typedef struct { bit eb, em, bold, bf, mf, bwe, mwe; bit [4:0] brd, mrd; bit [31:0] bd, md; } ment_t;

  int n_cmp = 0, n_bad = 0;
  ment_t mq[$];
  logic [1:0]  e_we, e_cnt, e_real;
  logic [4:0]  e_wa[2];
  logic [31:0] e_wd[2];
  logic [31:0] e_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] iss, input logic fl, input logic [6:0] br, input logic [31:0] bd,
                              input logic [6:0] mr, input logic [31:0] md, input logic [2:0] rdy, input logic [2:0] occ,
                              input logic [1:0] we, input logic [1:0] cnt, input logic [1:0] chkm,
                              input logic [4:0] wa0, input logic [31:0] wd0, input logic [4:0] wa1, input logic [31:0] wd1);
    vec_t v;
    v = '0;
    {v.i.iv, v.i.bv, v.i.mv, v.i.pri} = iss;
    v.i.fl = fl;
    {v.i.brv, v.i.bwe, v.i.brd} = br; v.i.bd = bd;
    {v.i.mrv, v.i.mwe, v.i.mrd} = mr; v.i.md = md;
    {v.e.ir, v.e.brr, v.e.mrr} = rdy;
    v.e.occ = occ; v.e.we = we; v.e.cnt = cnt; v.e.chk = chkm;
    v.e.wa0 = wa0; v.e.wd0 = wd0; v.e.wa1 = wa1; v.e.wd1 = wd1;
    return v;
  endfunction

  function automatic int find_br();
    for (int k = 0; k < mq.size(); k++) if (mq[k].eb && !mq[k].bf) return k;
    return -1;
  endfunction
  function automatic int find_mem();
    for (int k = 0; k < mq.size(); k++) if (mq[k].em && !mq[k].mf) return k;
    return -1;
  endfunction

  task automatic model_clear();
    mq.delete();
    e_we = '0; e_cnt = '0; e_real = '0; e_total = '0;
    e_wa[0] = '0; e_wa[1] = '0; e_wd[0] = '0; e_wd[1] = '0;
  endtask

  // Retire one pair: older slot to port 0, rd==0 never writes, younger wins on equal rd.
  task automatic model_retire(input ment_t h);
    bit r[2], w[2], we[2];
    if (h.bold) begin
      r[0] = h.eb; we[0] = h.bwe; e_wa[0] = h.brd; e_wd[0] = h.bd;
      r[1] = h.em; we[1] = h.mwe; e_wa[1] = h.mrd; e_wd[1] = h.md;
    end else begin
      r[0] = h.em; we[0] = h.mwe; e_wa[0] = h.mrd; e_wd[0] = h.md;
      r[1] = h.eb; we[1] = h.bwe; e_wa[1] = h.brd; e_wd[1] = h.bd;
    end
    for (int i = 0; i < 2; i++) w[i] = r[i] && we[i] && (e_wa[i] != 5'd0);
    if (w[0] && w[1] && e_wa[0] == e_wa[1]) w[0] = 1'b0;
    e_we   = {w[1], w[0]};
    e_real = {r[1], r[0]};
    e_cnt  = 2'(int'(r[0]) + int'(r[1]));
  endtask

  task automatic model_edge(input in_t v, input bit pa, input bit ba, input bit ma);
    bit pop;
    int k;
    ment_t t;
    if (PERF) e_total = e_total + 32'(e_cnt);
    if (v.fl) begin
      mq.delete(); e_we = '0; e_cnt = '0; e_real = '0;
      return;
    end
    pop = (mq.size() > 0) && (!mq[0].eb || mq[0].bf) && (!mq[0].em || mq[0].mf);
    if (pop) model_retire(mq[0]);
    else begin e_we = '0; e_cnt = '0; e_real = '0; end
    if (ba) begin
      k = find_br(); t = mq[k];
      t.bf = 1'b1; t.bwe = v.bwe; t.brd = v.brd; t.bd = v.bd; mq[k] = t;
    end
    if (ma) begin
      k = find_mem(); t = mq[k];
      t.mf = 1'b1; t.mwe = v.mwe; t.mrd = v.mrd; t.md = v.md; mq[k] = t;
    end
    if (pop) void'(mq.pop_front());
    if (pa && (v.bv || v.mv)) begin
      t = '{default: '0};
      t.eb = v.bv; t.em = v.mv; t.bold = (v.pri != 2'b01);
      mq.push_back(t);
    end
  endtask

  task automatic drive(input in_t v);
    cu.issue_valid = v.iv; cu.issue_br_valid = v.bv; cu.issue_mem_valid = v.mv;
    cu.issue_priority = v.pri; cu.flush = v.fl;
    cu.br_res_valid = v.brv; cu.br_res_we = v.bwe; cu.br_res_rd = v.brd; cu.br_res_data = v.bd;
    cu.mem_res_valid = v.mrv; cu.mem_res_we = v.mwe; cu.mem_res_rd = v.mrd; cu.mem_res_data = v.md;
  endtask

  // One clock: drive at falling edge, check ready, advance model at rising edge, check outputs at next falling edge.
  task automatic run_cycle(input in_t v, input bit use_tbl, input ex_t e, input int row);
    bit m_ir, m_brr, m_mrr;
    drive(v);
    #1;
    m_ir  = (mq.size() < D) && !v.fl;
    m_brr = !v.fl && (find_br() >= 0);
    m_mrr = !v.fl && (find_mem() >= 0);
    chk("issue_ready", 32'(cu.issue_ready), 32'(m_ir));
    chk("br_res_ready", 32'(cu.br_res_ready), 32'(m_brr));
    chk("mem_res_ready", 32'(cu.mem_res_ready), 32'(m_mrr));
    if (use_tbl) begin
      chk($sformatf("row%0d issue_ready", row), 32'(cu.issue_ready), 32'(e.ir));
      chk($sformatf("row%0d br_res_ready", row), 32'(cu.br_res_ready), 32'(e.brr));
      chk($sformatf("row%0d mem_res_ready", row), 32'(cu.mem_res_ready), 32'(e.mrr));
    end
    @(posedge clk);
    model_edge(v, v.iv && m_ir, v.brv && m_brr, v.mrv && m_mrr);
    @(negedge clk);
    chk("occupancy", 32'(cu.occupancy), 32'(mq.size()));
    chk("rf_we", 32'(cu.rf_we), 32'(e_we));
    chk("retire_count", 32'(cu.retire_count), 32'(e_cnt));
    chk("retired_total", cu.retired_total, e_total);
    for (int i = 0; i < 2; i++) if (e_real[i]) begin
      chk($sformatf("rf_waddr[%0d]", i), 32'(cu.rf_waddr[i]), 32'(e_wa[i]));
      chk($sformatf("rf_wdata[%0d]", i), cu.rf_wdata[i], e_wd[i]);
    end
    if (use_tbl) begin
      chk($sformatf("row%0d occupancy", row), 32'(cu.occupancy), 32'(e.occ));
      chk($sformatf("row%0d rf_we", row), 32'(cu.rf_we), 32'(e.we));
      chk($sformatf("row%0d retire_count", row), 32'(cu.retire_count), 32'(e.cnt));
      if (e.chk[0]) begin
        chk($sformatf("row%0d waddr0", row), 32'(cu.rf_waddr[0]), 32'(e.wa0));
        chk($sformatf("row%0d wdata0", row), cu.rf_wdata[0], e.wd0);
      end
      if (e.chk[1]) begin
        chk($sformatf("row%0d waddr1", row), 32'(cu.rf_waddr[1]), 32'(e.wa1));
        chk($sformatf("row%0d wdata1", row), cu.rf_wdata[1], e.wd1);
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear without waiting for an edge.
  task automatic do_reset();
    drive(in_t'('0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst occupancy", 32'(cu.occupancy), 32'd0);
    chk("rst rf_we", 32'(cu.rf_we), 32'd0);
    chk("rst retire_count", 32'(cu.retire_count), 32'd0);
    chk("rst rf_waddr", 32'(cu.rf_waddr), 32'd0);
    chk("rst rf_wdata0", cu.rf_wdata[0], 32'd0);
    chk("rst rf_wdata1", cu.rf_wdata[1], 32'd0);
    chk("rst retired_total", cu.retired_total, 32'd0);
    chk("rst issue_ready", 32'(cu.issue_ready), 32'd1);
    chk("rst br_res_ready", 32'(cu.br_res_ready), 32'd0);
    chk("rst mem_res_ready", 32'(cu.mem_res_ready), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic in_t rnd_in();
    in_t v;
    v = '0;
    v.iv  = ($urandom_range(0, 3) != 0);
    v.bv  = 1'($urandom_range(0, 1));
    v.mv  = 1'($urandom_range(0, 1));
    v.pri = 2'($urandom_range(0, 3));
    v.fl  = ($urandom_range(0, 49) == 0);
    v.brv = 1'($urandom_range(0, 1));
    v.bwe = ($urandom_range(0, 3) != 0);
    v.brd = 5'($urandom_range(0, 3));
    v.bd  = $urandom();
    v.mrv = 1'($urandom_range(0, 1));
    v.mwe = ($urandom_range(0, 3) != 0);
    v.mrd = 5'($urandom_range(0, 3));
    v.md  = $urandom();
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    in_t  v;
    ex_t  ez;
    ez = '0;
    model_clear();
    drive(in_t'('0));
    //            iss       fl    br              bd      mr              md      rdy     occ   we     cnt   chk    wa0   wd0     wa1   wd1
    tbl.push_back(mk(5'b11110, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b111, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, {2'b11, 5'd3},  32'h11,  7'd0,           32'h0,  3'b111, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b101, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b101, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   {2'b11, 5'd4},  32'h22, 3'b101, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b11, 2'd2, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11101, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, {2'b11, 5'd7},  32'hB,   {2'b11, 5'd7},  32'hA,  3'b111, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b10, 2'd2, 2'b11, 5'd7, 32'hA,  5'd7, 32'hB));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, {2'b11, 5'd0},  32'h55,  7'd0,           32'h0,  3'b110, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b00, 2'd1, 2'b01, 5'd0, 32'h55, 5'd0, 32'h0));
    tbl.push_back(mk(5'b10111, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   {2'b11, 5'd9},  32'h77, 3'b101, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b10, 2'd1, 2'b10, 5'd0, 32'h0,  5'd9, 32'h77));
    tbl.push_back(mk(5'b11010, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b110, 3'd2, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b110, 3'd3, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b110, 3'd4, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, {2'b11, 5'd1},  32'h101, 7'd0,           32'h0,  3'b010, 3'd4, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b010, 3'd3, 2'b01, 2'd1, 2'b01, 5'd1, 32'h101, 5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b110, 3'd3, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11110, 1'b1, {2'b11, 5'd2},  32'h5,   7'd0,           32'h0,  3'b000, 3'd0, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11110, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b11010, 1'b0, {2'b11, 5'd5},  32'h50,  7'd0,           32'h0,  3'b111, 3'd2, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, {2'b11, 5'd6},  32'h60,  7'd0,           32'h0,  3'b111, 3'd2, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b101, 3'd2, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   {2'b11, 5'd8},  32'h80, 3'b101, 3'd2, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd1, 2'b11, 2'd2, 2'b11, 5'd5, 32'h50, 5'd8, 32'h80));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b01, 2'd1, 2'b01, 5'd6, 32'h60, 5'd0, 32'h0));
    tbl.push_back(mk(5'b00000, 1'b0, 7'd0,           32'h0,   7'd0,           32'h0,  3'b100, 3'd0, 2'b00, 2'd0, 2'b00, 5'd0, 32'h0,  5'd0, 32'h0));

    repeat (2) @(negedge clk);
    do_reset();

    for (int r = 0; r < tbl.size(); r++) run_cycle(tbl[r].i, 1'b1, tbl[r].e, r);

    // Performance counter: five full pairs and one single retire; flush must not clear the total.
    do_reset();
    for (int p = 0; p < 6; p++) begin
      v = '0; v.iv = 1'b1; v.bv = 1'b1; v.mv = (p < 5); v.pri = 2'b10;
      run_cycle(v, 1'b0, ez, 0);
      v = '0;
      v.brv = 1'b1; v.bwe = 1'b1; v.brd = 5'(p + 1); v.bd = 32'(p);
      v.mrv = (p < 5); v.mwe = 1'b1; v.mrd = 5'(p + 10); v.md = 32'(p + 100);
      run_cycle(v, 1'b0, ez, 0);
    end
    repeat (3) run_cycle(in_t'('0), 1'b0, ez, 0);
    chk("perf retired_total", cu.retired_total, PERF ? 32'd11 : 32'd0);
    v = '0; v.fl = 1'b1;
    run_cycle(v, 1'b0, ez, 0);
    repeat (2) run_cycle(in_t'('0), 1'b0, ez, 0);
    chk("perf retired_total after flush", cu.retired_total, PERF ? 32'd11 : 32'd0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      run_cycle(rnd_in(), 1'b0, ez, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
